instr_queue: RTL and testbench

Parametrised instruction queue replacing the single-word edge-triggered instruction register between the memory fetch path and the control unit. It holds up to DEPTH fetched instruction words, each tagged with its fetch address, in a synchronous first-word-fall-through FIFO. Both sides use valid/ready handshakes, and a flush input discards all held words on a taken branch or jump. All state is clocked by one clock, so fetch can run ahead of decode without a separate enable edge.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/ibuf_mem.sv | 32 +++
 rtl/instr_queue.sv | 97 +++++++++
 tb/tb_instr_queue.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared CPU definitions used by the fetch/decode path.
//   INSTR_W      : default instruction word width
//   PC_W         : default fetch-address width
//   ibuf_entry_t : one instruction-queue entry, {instr, pc}
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } ibuf_entry_t;

endpackage

// File: rtl/ibuf_mem.sv
// ibuf_mem
// Instruction-queue storage array: synchronous write port, asynchronous read port.
// Contents are not reset; validity is tracked by the owner's count.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write index
//   wdata_i : write data
//   raddr_i : read index
//   rdata_o : read data (combinational)
module ibuf_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_queue.sv
// instr_queue
// First-word-fall-through instruction queue between fetch and decode.
// Holds up to DEPTH {instr, pc} entries; flush discards all held entries.
//   clk, rst             : clock, synchronous active-high reset
//   flush                : drop all entries (priority over push/pop)
//   in_valid/in_ready    : fetch-side handshake
//   in_instr, in_pc      : fetched word and its address
//   out_valid/out_ready  : decode-side handshake
//   out_instr, out_pc    : head entry (valid only while out_valid)
//   count                : number of held entries
module instr_queue
  import cpu_pkg::*;
#(
  parameter int WIDTH = INSTR_W,
  parameter int PC_W  = cpu_pkg::PC_W,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_instr,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_instr,
  output logic [PC_W-1:0]            out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int ENT_W = WIDTH + PC_W;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop, mem_we;
  logic [ENT_W-1:0] rdata;

  // Full/empty come from count only, so in_ready never depends on out_ready
  // and out_valid never depends on in_valid.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A write that coincides with flush or reset is dropped so the
  // discarded handshake leaves storage untouched.
  assign mem_we = push & ~flush & ~rst;

  ibuf_mem #(
    .DEPTH(DEPTH),
    .W    (ENT_W)
  ) u_mem (
    .clk    (clk),
    .we_i   (mem_we),
    .waddr_i(wr_ptr_q),
    .wdata_i({in_instr, in_pc}),
    .raddr_i(rd_ptr_q),
    .rdata_o(rdata)
  );

  assign out_instr = rdata[ENT_W-1:PC_W];
  assign out_pc    = rdata[PC_W-1:0];

endmodule

// File: tb/tb_instr_queue.sv
module tb_instr_queue;

  localparam int WIDTH = 32;
  localparam int PC_W  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_instr, out_instr;
  logic [PC_W-1:0]  in_pc, out_pc;
  logic [CNT_W-1:0] count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_queue #(
    .WIDTH(WIDTH),
    .PC_W (PC_W),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_instr (in_instr),
    .in_pc    (in_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc   (out_pc),
    .count    (count)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ordy;
    int          ecnt;
    logic        eov;
    logic        eir;
    logic        chead;
    logic [31:0] epc;
    logic [31:0] einstr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] iw(input logic [31:0] pc);
    return 32'h1000_0000 | pc;
  endfunction

  task automatic add(input logic r, input logic f, input logic iv, input logic [31:0] pc,
                     input logic [31:0] instr, input logic ordy, input int ecnt,
                     input logic eov, input logic eir, input logic chead,
                     input logic [31:0] epc, input logic [31:0] einstr);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.pc = pc; v.instr = instr; v.ordy = ordy;
    v.ecnt = ecnt; v.eov = eov; v.eir = eir; v.chead = chead; v.epc = epc; v.einstr = einstr;
    tbl.push_back(v);
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
  endtask

  logic [63:0] mq[$];
  logic        hold;
  logic        m_push, m_pop;
  logic [63:0] head;

  initial begin
    idle();
    rst = 1'b1;

    // reset; basic push/pop; fill to full; push+pop at 2 and at full; flush; reset mid-stream
    add(1,0,0,32'h0 ,32'h0       ,0, 0,0,1,0,32'h0 ,32'h0);
    add(0,0,1,32'h0 ,32'h00500093,0, 1,1,1,1,32'h0 ,32'h00500093);
    add(0,0,0,32'h0 ,32'h0       ,1, 0,0,1,0,32'h0 ,32'h0);
    add(0,0,1,32'h0 ,iw(32'h0)   ,0, 1,1,1,1,32'h0 ,iw(32'h0));
    add(0,0,1,32'h4 ,iw(32'h4)   ,0, 2,1,1,1,32'h0 ,iw(32'h0));
    add(0,0,1,32'h8 ,iw(32'h8)   ,0, 3,1,1,1,32'h0 ,iw(32'h0));
    add(0,0,1,32'hC ,iw(32'hC)   ,0, 4,1,0,1,32'h0 ,iw(32'h0));
    add(0,0,1,32'h10,iw(32'h10)  ,0, 4,1,0,1,32'h0 ,iw(32'h0));
    add(0,0,1,32'h10,iw(32'h10)  ,1, 3,1,1,1,32'h4 ,iw(32'h4));
    add(0,0,0,32'h0 ,32'h0       ,1, 2,1,1,1,32'h8 ,iw(32'h8));
    add(0,0,1,32'h10,iw(32'h10)  ,1, 2,1,1,1,32'hC ,iw(32'hC));
    add(0,0,0,32'h0 ,32'h0       ,1, 1,1,1,1,32'h10,iw(32'h10));
    add(0,0,1,32'h14,iw(32'h14)  ,0, 2,1,1,1,32'h10,iw(32'h10));
    add(0,0,1,32'h18,iw(32'h18)  ,0, 3,1,1,1,32'h10,iw(32'h10));
    add(0,1,1,32'h1C,iw(32'h1C)  ,1, 0,0,1,0,32'h0 ,32'h0);
    add(0,0,1,32'h40,iw(32'h40)  ,0, 1,1,1,1,32'h40,iw(32'h40));
    add(0,0,0,32'h0 ,32'h0       ,1, 0,0,1,0,32'h0 ,32'h0);
    add(0,0,1,32'h50,iw(32'h50)  ,0, 1,1,1,1,32'h50,iw(32'h50));
    add(0,0,1,32'h54,iw(32'h54)  ,0, 2,1,1,1,32'h50,iw(32'h50));
    add(1,0,1,32'h58,iw(32'h58)  ,1, 0,0,1,0,32'h0 ,32'h0);
    add(0,0,1,32'h60,iw(32'h60)  ,0, 1,1,1,1,32'h60,iw(32'h60));
    add(0,0,0,32'h0 ,32'h0       ,1, 0,0,1,0,32'h0 ,32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; flush = tbl[i].flush; in_valid = tbl[i].iv;
      in_pc = tbl[i].pc; in_instr = tbl[i].instr; out_ready = tbl[i].ordy;
      tick();
      chk($sformatf("row%0d count", i), 32'(count), 32'(tbl[i].ecnt));
      chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].eov));
      chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].eir));
      if (tbl[i].chead) begin
        chk($sformatf("row%0d out_pc", i), out_pc, tbl[i].epc);
        chk($sformatf("row%0d out_instr", i), out_instr, tbl[i].einstr);
      end
    end

    // Streaming 10 words at one per cycle with the consumer always ready
    idle();
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_pc = 32'(k * 4); in_instr = iw(32'h200 + 32'(k)); out_ready = 1'b1;
      tick();
      chk($sformatf("stream%0d out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("stream%0d count", k), 32'(count), 32'd1);
      chk($sformatf("stream%0d out_pc", k), out_pc, 32'(k * 4));
      chk($sformatf("stream%0d out_instr", k), out_instr, iw(32'h200 + 32'(k)));
    end
    in_valid = 1'b0;
    tick();
    chk("stream drain count", 32'(count), 32'd0);
    chk("stream drain out_valid", 32'(out_valid), 32'd0);

    // Randomized traffic against a queue model
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mq.delete();
    hold = 1'b0;
    for (int c = 0; c < 1200; c++) begin
      if (!hold) begin
        in_instr = $urandom;
        in_pc    = $urandom;
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) < ((c / 64) % 4));
      flush     = ($urandom_range(0, 39) == 0);
      m_push = in_valid && (mq.size() < DEPTH);
      m_pop  = out_ready && (mq.size() != 0);
      tick();
      if (flush) begin
        mq.delete();
      end else begin
        if (m_pop)  void'(mq.pop_front());
        if (m_push) mq.push_back({in_instr, in_pc});
      end
      hold = in_valid && !m_push && !flush;
      chk($sformatf("rnd%0d count", c), 32'(count), 32'(mq.size()));
      chk($sformatf("rnd%0d out_valid", c), 32'(out_valid), 32'(mq.size() != 0));
      chk($sformatf("rnd%0d in_ready", c), 32'(in_ready), 32'(mq.size() < DEPTH));
      if (mq.size() != 0) begin
        head = mq[0];
        chk($sformatf("rnd%0d out_instr", c), out_instr, head[63:32]);
        chk($sformatf("rnd%0d out_pc", c), out_pc, head[31:0]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
